mano_timing_control: RTL

- Hard-wired timing and control unit for the 16-bit basic computer.
- Owns the 4-bit sequence counter (SC), the indirect flip-flop I and the run flip-flop S.
- Decodes IR and drives the common-bus select plus load/increment/clear strobes for AR, PC, DR, IR, AC, E and memory.
- Sits between the register file (AR, PC, DR, IR, AC) and memory, and replaces the per-register decode logic.

---
 rtl/mano_timing_control.sv | 249 ++++++++++++++++++++++++
 1 files changed

// File: rtl/mano_timing_control.sv
// Hard-wired timing and control unit for the Mano basic computer: owns SC, I and S,
// and decodes IR into bus-select and register/memory strobes.
module mano_timing_control #(
    parameter int WORD_W = 16,
    parameter int SC_W   = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [WORD_W-1:0] IN_IR,
    input  logic              START,
    input  logic              AC_ZERO,
    input  logic              AC_SIGN,
    input  logic              E_FLAG,
    input  logic              DR_ZERO,
    output logic [SC_W-1:0]   SC,
    output logic [2:0]        BUS_SEL,
    output logic              LD_AR,
    output logic              INC_AR,
    output logic              CLR_AR,
    output logic              LD_PC,
    output logic              INC_PC,
    output logic              LD_IR,
    output logic              LD_DR,
    output logic              INC_DR,
    output logic              MEM_RD,
    output logic              MEM_WR,
    output logic [3:0]        AC_OP,
    output logic [1:0]        E_OP,
    output logic              IND,
    output logic              HALT
);

    typedef enum logic [SC_W-1:0] {
        T0 = SC_W'(0),
        T1 = SC_W'(1),
        T2 = SC_W'(2),
        T3 = SC_W'(3),
        T4 = SC_W'(4),
        T5 = SC_W'(5),
        T6 = SC_W'(6)
    } step_t;

    localparam logic [2:0] BUS_NONE = 3'd0;
    localparam logic [2:0] BUS_AR   = 3'd1;
    localparam logic [2:0] BUS_PC   = 3'd2;
    localparam logic [2:0] BUS_DR   = 3'd3;
    localparam logic [2:0] BUS_AC   = 3'd4;
    localparam logic [2:0] BUS_IR   = 3'd5;
    localparam logic [2:0] BUS_MEM  = 3'd7;

    localparam logic [3:0] AC_NOP  = 4'd0;
    localparam logic [3:0] AC_AND  = 4'd1;
    localparam logic [3:0] AC_ADD  = 4'd2;
    localparam logic [3:0] AC_LDR  = 4'd3;
    localparam logic [3:0] AC_CLR  = 4'd4;
    localparam logic [3:0] AC_CMA  = 4'd5;
    localparam logic [3:0] AC_CIR  = 4'd6;
    localparam logic [3:0] AC_CIL  = 4'd7;
    localparam logic [3:0] AC_INC  = 4'd8;

    localparam logic [1:0] E_NOP = 2'd0;
    localparam logic [1:0] E_CLR = 2'd1;
    localparam logic [1:0] E_CME = 2'd2;

    localparam logic [2:0] OP_AND = 3'd0;
    localparam logic [2:0] OP_ADD = 3'd1;
    localparam logic [2:0] OP_LDA = 3'd2;
    localparam logic [2:0] OP_STA = 3'd3;
    localparam logic [2:0] OP_BUN = 3'd4;
    localparam logic [2:0] OP_BSA = 3'd5;
    localparam logic [2:0] OP_ISZ = 3'd6;
    localparam logic [2:0] OP_REG = 3'd7;

    logic [SC_W-1:0] sc_q;
    logic            ind_q;
    logic            run_q;

    logic [2:0]  opcode;
    logic [11:0] b_field;
    logic        active;

    logic [2:0]  bus;
    logic        ld_ar, inc_ar, ld_pc, inc_pc, ld_ir, ld_dr, inc_dr, mem_rd, mem_wr;
    logic [3:0]  ac_op;
    logic [1:0]  e_op;
    logic        clr_sc;
    logic        hlt_req;

    assign opcode  = IN_IR[WORD_W-2 -: 3];
    assign b_field = IN_IR[11:0];
    assign active  = run_q && !RST;

    always_ff @(posedge CLK) begin
        if (RST) begin
            sc_q  <= '0;
            ind_q <= 1'b0;
            run_q <= 1'b1;
        end else if (!run_q) begin
            sc_q <= '0;
            if (START) begin
                run_q <= 1'b1;
            end
        end else begin
            sc_q <= clr_sc ? '0 : sc_q + SC_W'(1);
            if (sc_q == T2) begin
                ind_q <= IN_IR[WORD_W-1];
            end
            if (hlt_req) begin
                run_q <= 1'b0;
            end
        end
    end

    // Raw step decode; gated by run/reset at the ports. Unlisted or unreachable steps clear SC.
    always_comb begin
        bus     = BUS_NONE;
        ld_ar   = 1'b0;
        inc_ar  = 1'b0;
        ld_pc   = 1'b0;
        inc_pc  = 1'b0;
        ld_ir   = 1'b0;
        ld_dr   = 1'b0;
        inc_dr  = 1'b0;
        mem_rd  = 1'b0;
        mem_wr  = 1'b0;
        ac_op   = AC_NOP;
        e_op    = E_NOP;
        clr_sc  = 1'b0;
        hlt_req = 1'b0;

        case (sc_q)
            T0: begin
                bus   = BUS_PC;
                ld_ar = 1'b1;
            end
            T1: begin
                bus    = BUS_MEM;
                mem_rd = 1'b1;
                ld_ir  = 1'b1;
                inc_pc = 1'b1;
            end
            T2: begin
                bus   = BUS_IR;
                ld_ar = 1'b1;
            end
            T3: begin
                if (opcode != OP_REG) begin
                    if (ind_q) begin
                        bus    = BUS_MEM;
                        mem_rd = 1'b1;
                        ld_ar  = 1'b1;
                    end
                end else if (!ind_q) begin
                    clr_sc = 1'b1;
                    if (b_field[11])      ac_op = AC_CLR;
                    else if (b_field[9])  ac_op = AC_CMA;
                    else if (b_field[7])  ac_op = AC_CIR;
                    else if (b_field[6])  ac_op = AC_CIL;
                    else if (b_field[5])  ac_op = AC_INC;
                    if (b_field[10])      e_op = E_CLR;
                    else if (b_field[8])  e_op = E_CME;
                    if ((b_field[4] && !AC_SIGN) || (b_field[3] && AC_SIGN) ||
                        (b_field[2] && AC_ZERO)  || (b_field[1] && !E_FLAG)) begin
                        inc_pc = 1'b1;
                    end
                    hlt_req = b_field[0];
                end else begin
                    clr_sc = 1'b1;
                end
            end
            T4: begin
                case (opcode)
                    OP_AND, OP_ADD, OP_LDA, OP_ISZ: begin
                        bus    = BUS_MEM;
                        mem_rd = 1'b1;
                        ld_dr  = 1'b1;
                    end
                    OP_STA: begin
                        bus    = BUS_AC;
                        mem_wr = 1'b1;
                        clr_sc = 1'b1;
                    end
                    OP_BUN: begin
                        bus    = BUS_AR;
                        ld_pc  = 1'b1;
                        clr_sc = 1'b1;
                    end
                    OP_BSA: begin
                        bus    = BUS_PC;
                        mem_wr = 1'b1;
                        inc_ar = 1'b1;
                    end
                    default: clr_sc = 1'b1;
                endcase
            end
            T5: begin
                case (opcode)
                    OP_AND: begin
                        ac_op  = AC_AND;
                        clr_sc = 1'b1;
                    end
                    OP_ADD: begin
                        ac_op  = AC_ADD;
                        clr_sc = 1'b1;
                    end
                    OP_LDA: begin
                        ac_op  = AC_LDR;
                        clr_sc = 1'b1;
                    end
                    OP_BSA: begin
                        bus    = BUS_AR;
                        ld_pc  = 1'b1;
                        clr_sc = 1'b1;
                    end
                    OP_ISZ: inc_dr = 1'b1;
                    default: clr_sc = 1'b1;
                endcase
            end
            T6: begin
                clr_sc = 1'b1;
                if (opcode == OP_ISZ) begin
                    bus    = BUS_DR;
                    mem_wr = 1'b1;
                    inc_pc = DR_ZERO;
                end
            end
            default: clr_sc = 1'b1;
        endcase
    end

    assign SC      = sc_q;
    assign IND     = ind_q;
    assign HALT    = !run_q && !RST;
    assign BUS_SEL = active ? bus : BUS_NONE;
    assign LD_AR   = active && ld_ar;
    assign INC_AR  = active && inc_ar;
    // No instruction in this set clears AR.
    assign CLR_AR  = 1'b0;
    assign LD_PC   = active && ld_pc;
    assign INC_PC  = active && inc_pc;
    assign LD_IR   = active && ld_ir;
    assign LD_DR   = active && ld_dr;
    assign INC_DR  = active && inc_dr;
    assign MEM_RD  = active && mem_rd;
    assign MEM_WR  = active && mem_wr;
    assign AC_OP   = active ? ac_op : AC_NOP;
    assign E_OP    = active ? e_op : E_NOP;

endmodule
